oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 153 +++++++++++++++
 tb/tb_oam_dma.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM DMA engine: snoops CPU writes to 16'h4014, halts the CPU and copies
// one 256-byte page into the OAM data port at 16'h2004, one read and one
// write per byte, with every read aligned to an even cycle.
module oam_dma (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_r_nw,
    input  logic [7:0]  Data_bus_in,
    output logic        rdy,
    output logic        dma_busy,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_data_out,
    output logic        dma_r_nw
);

    localparam logic [15:0] TRIG_ADDR = 16'h4014;
    localparam logic [15:0] OAM_ADDR  = 16'h2004;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HALT  = 3'd1;
    localparam logic [2:0] ST_ALIGN = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        parity_q, parity_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  byte_q, byte_d;
    logic        rdy_q, rdy_d;
    logic        busy_q, busy_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        r_nw_q, r_nw_d;

    // Next-state logic: trigger detect (IDLE only), alignment and byte walk.
    always_comb begin
        state_d  = state_q;
        parity_d = ~parity_q;
        page_d   = page_q;
        index_d  = index_q;
        byte_d   = byte_q;
        case (state_q)
            ST_IDLE: begin
                if ((cpu_addr == TRIG_ADDR) && (cpu_r_nw == 1'b0)) begin
                    page_d  = cpu_data_out;
                    index_d = 8'h00;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                // An odd halt cycle is followed by an even one, so read at once.
                if (parity_q == 1'b1) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                byte_d  = Data_bus_in;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                index_d = index_q + 8'd1;
                if (index_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        rdy_d  = 1'b1;
        busy_d = 1'b0;
        addr_d = 16'h0000;
        data_d = 8'h00;
        r_nw_d = 1'b1;
        case (state_d)
            ST_IDLE: begin
                rdy_d  = 1'b1;
                busy_d = 1'b0;
            end
            ST_HALT, ST_ALIGN: begin
                rdy_d  = 1'b0;
                busy_d = 1'b1;
                addr_d = TRIG_ADDR;
            end
            ST_READ: begin
                rdy_d  = 1'b0;
                busy_d = 1'b1;
                addr_d = {page_d, index_d};
            end
            ST_WRITE: begin
                rdy_d  = 1'b0;
                busy_d = 1'b1;
                addr_d = OAM_ADDR;
                data_d = byte_d;
                r_nw_d = 1'b0;
            end
            default: begin
                rdy_d  = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset to the idle bus.
    always_ff @(posedge clk_ph1 or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            index_q  <= 8'h00;
            byte_q   <= 8'h00;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
            addr_q   <= 16'h0000;
            data_q   <= 8'h00;
            r_nw_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            page_q   <= page_d;
            index_q  <= index_d;
            byte_q   <= byte_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            r_nw_q   <= r_nw_d;
        end
    end

    assign rdy          = rdy_q;
    assign dma_busy     = busy_q;
    assign dma_addr     = addr_q;
    assign dma_data_out = data_q;
    assign dma_r_nw     = r_nw_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a bus-cycle scoreboard.
module tb_oam_dma;

    logic        clk_ph1;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_r_nw;
    logic [7:0]  Data_bus_in;
    logic        rdy;
    logic        dma_busy;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;
    logic        dma_r_nw;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic        rnw;
        logic [7:0]  data;
        logic [7:0]  idx;
    } bus_cyc_t;

    bus_cyc_t exp_q[$];
    logic     tb_par;

    oam_dma dut (
        .clk_ph1     (clk_ph1),
        .rst         (rst),
        .cpu_addr    (cpu_addr),
        .cpu_data_out(cpu_data_out),
        .cpu_r_nw    (cpu_r_nw),
        .Data_bus_in (Data_bus_in),
        .rdy         (rdy),
        .dma_busy    (dma_busy),
        .dma_addr    (dma_addr),
        .dma_data_out(dma_data_out),
        .dma_r_nw    (dma_r_nw)
    );

    initial clk_ph1 = 1'b0;
    always #5 clk_ph1 = ~clk_ph1;

    // Memory responder: low address byte XOR 8'hA5.
    assign Data_bus_in = dma_addr[7:0] ^ 8'hA5;

    // Reference cycle parity.
    always @(posedge clk_ph1 or posedge rst) begin
        if (rst) tb_par <= 1'b0;
        else     tb_par <= ~tb_par;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " rdy"},  {31'd0, rdy}, 32'd1);
        chk({tag, " busy"}, {31'd0, dma_busy}, 32'd0);
        chk({tag, " addr"}, {16'd0, dma_addr}, 32'h0000);
        chk({tag, " data"}, {24'd0, dma_data_out}, 32'h00);
        chk({tag, " rnw"},  {31'd0, dma_r_nw}, 32'd1);
    endtask

    // Trigger so that the HALT cycle has the requested parity.
    task automatic do_trigger(input logic [7:0] page, input logic odd);
        @(negedge clk_ph1);
        if (tb_par == odd) @(negedge clk_ph1);
        cpu_addr = 16'h4014; cpu_r_nw = 1'b0; cpu_data_out = page;
        @(posedge clk_ph1);
        #1;
        cpu_addr = 16'h0000; cpu_r_nw = 1'b1; cpu_data_out = 8'h00;
    endtask

    task automatic push_page(input logic [7:0] page);
        bus_cyc_t c;
        for (int i = 0; i < 256; i++) begin
            c.addr = {page, i[7:0]}; c.rnw = 1'b1; c.data = 8'h00; c.idx = i[7:0];
            exp_q.push_back(c);
            c.addr = 16'h2004; c.rnw = 1'b0; c.data = i[7:0] ^ 8'hA5;
            exp_q.push_back(c);
        end
    endtask

    // Watch one transfer; inject=1 pokes 16'h4014 at READ of index 8'h10,
    // abort=1 pulses rst during WRITE of index 8'h40.
    task automatic run_transfer(input string tag, input int exp_len, input bit inject, input bit abort);
        int lowcnt = 0;
        int halts = 0;
        bit started = 0;
        bit done = 0;
        bus_cyc_t e;
        for (int n = 0; n < 700 && !done; n++) begin
            @(negedge clk_ph1);
            cpu_addr = 16'h0000; cpu_r_nw = 1'b1; cpu_data_out = 8'h00;
            if (rdy == 1'b0) lowcnt++;
            else if (lowcnt > 0) begin
                chk_idle({tag, " end"});
                done = 1;
            end
            if (!done && dma_busy) begin
                chk({tag, " rdy_n"}, {31'd0, rdy}, 32'd0);
                if (!started && dma_addr == 16'h4014 && dma_r_nw == 1'b1) begin
                    halts++;
                end else if (exp_q.size() == 0) begin
                    chk({tag, " extra cycle"}, {16'd0, dma_addr}, 32'hFFFFFFFF);
                end else begin
                    started = 1;
                    e = exp_q.pop_front();
                    chk({tag, " addr"}, {16'd0, dma_addr}, {16'd0, e.addr});
                    chk({tag, " rnw"}, {31'd0, dma_r_nw}, {31'd0, e.rnw});
                    if (e.rnw) chk({tag, " read parity"}, {31'd0, tb_par}, 32'd0);
                    else       chk({tag, " wdata"}, {24'd0, dma_data_out}, {24'd0, e.data});
                    if (inject && e.rnw && e.idx == 8'h10) begin
                        cpu_addr = 16'h4014; cpu_r_nw = 1'b0; cpu_data_out = 8'h07;
                    end
                    if (abort && !e.rnw && e.idx == 8'h40) begin
                        rst = 1'b1;
                        #1;
                        chk_idle({tag, " abort"});
                        #2;
                        rst = 1'b0;
                        exp_q.delete();
                        done = 1;
                    end
                end
            end
        end
        chk({tag, " completed"}, {31'd0, done}, 32'd1);
        if (!abort) begin
            chk({tag, " halt length"}, lowcnt, exp_len);
            chk({tag, " halt/align cycles"}, halts, exp_len - 512);
            chk({tag, " queue empty"}, exp_q.size(), 0);
        end
        exp_q.delete();
    endtask

    task automatic quiet(input string tag, input int cycles);
        int bad = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk_ph1);
            if (rdy !== 1'b1 || dma_busy !== 1'b0) bad++;
        end
        chk({tag, " stayed idle"}, bad, 0);
    endtask

    initial begin
        rst = 1'b1;
        cpu_addr = 16'h0000; cpu_data_out = 8'h00; cpu_r_nw = 1'b1;
        #12;
        chk_idle("reset");
        @(negedge clk_ph1);
        rst = 1'b0;

        // CPU read of the trigger and writes to neighbours do nothing.
        @(negedge clk_ph1);
        cpu_addr = 16'h4014; cpu_r_nw = 1'b1; cpu_data_out = 8'h02;
        @(negedge clk_ph1);
        cpu_addr = 16'h4013; cpu_r_nw = 1'b0;
        @(negedge clk_ph1);
        cpu_addr = 16'h4015; cpu_r_nw = 1'b0;
        @(negedge clk_ph1);
        cpu_addr = 16'h0000; cpu_r_nw = 1'b1; cpu_data_out = 8'h00;
        quiet("no trigger", 8);

        // Odd-parity halt: 513 cycles.
        push_page(8'h02);
        do_trigger(8'h02, 1'b1);
        run_transfer("odd", 513, 1'b0, 1'b0);
        quiet("after odd", 4);

        // Even-parity halt: one ALIGN cycle, 514 cycles.
        push_page(8'h02);
        do_trigger(8'h02, 1'b0);
        run_transfer("even", 514, 1'b0, 1'b0);

        // Trigger write during the transfer is ignored.
        push_page(8'h02);
        do_trigger(8'h02, 1'b1);
        run_transfer("inject", 513, 1'b1, 1'b0);
        quiet("after inject", 4);

        // Reset mid-transfer aborts, then a fresh page-3 transfer runs.
        push_page(8'h02);
        do_trigger(8'h02, 1'b0);
        run_transfer("abort", 514, 1'b0, 1'b1);
        quiet("after abort", 20);
        push_page(8'h03);
        do_trigger(8'h03, 1'b1);
        run_transfer("page3", 513, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
